// File: rtl/isp1761_bus_responder_pkg.sv
// Shared types and constants for the ISP1761 bus responder.
//   state_e            : responder FSM states
//   AddrWidth          : ISP1761 word address width (A[17:1])
//   AvAddrWidth        : local Avalon word address width
//   DataWidth          : bus and Avalon data width
//   TimeoutDataDefault : read data returned when an Avalon read times out
package isp1761_bus_responder_pkg;

  localparam int unsigned AddrWidth   = 17;
  localparam int unsigned AvAddrWidth = 16;
  localparam int unsigned DataWidth   = 32;

  localparam logic [DataWidth-1:0] TimeoutDataDefault = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StDrive,
    StWaitRelease
  } state_e;

endpackage

// File: rtl/isp1761_bus_responder_if.sv
// Avalon-MM link between the responder (master) and the local register file (slave).
//   address/read/write/writedata : master -> slave request
//   readdata/waitrequest         : slave -> master response
interface isp1761_bus_responder_if;
  import isp1761_bus_responder_pkg::*;

  logic [AvAddrWidth-1:0] address;
  logic                   read;
  logic                   write;
  logic [DataWidth-1:0]   writedata;
  logic [DataWidth-1:0]   readdata;
  logic                   waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );

endinterface

// File: rtl/isp1761_sync_bit.sv
// Single-bit multi-flop synchroniser for an asynchronous bus strobe.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, loads RESET_VALUE into every stage
//   d_i   : asynchronous input
//   q_o   : synchronised output, SYNC_STAGES clocks behind d_i
module isp1761_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VALUE = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/isp1761_bus_responder.sv
// Device-side ISP1761 parallel-bus responder. Synchronises the host strobes, turns every
// strobe assertion into exactly one Avalon-MM transfer and drives read data back onto D.
//   csi_clk, csi_reset : clock and synchronous active-high reset
//   CS_N/RD_N/WR_N     : asynchronous active-low bus strobes
//   A[17:1], D         : bus word address and bidirectional data (A[17] ignored)
//   m                  : Avalon-MM master port to the local register file
//   irq_in -> HC_IRQ   : local interrupt, registered once, to the host
//   err_sticky         : set on RD+WR together (or Avalon timeout); cleared only by reset
// Optional: define ISP1761_RESP_TIMEOUT_EN to abort Avalon transfers stalled for
// TIMEOUT_CYCLES cycles; a timed-out read returns TIMEOUT_DATA.
module isp1761_bus_responder
  import isp1761_bus_responder_pkg::*;
#(
  parameter int unsigned          SYNC_STAGES    = 2,
  parameter int unsigned          TIMEOUT_CYCLES = 255,
  parameter logic [DataWidth-1:0] TIMEOUT_DATA   = TimeoutDataDefault
) (
  input  logic                  csi_clk,
  input  logic                  csi_reset,
  input  logic                  CS_N,
  input  logic                  RD_N,
  input  logic                  WR_N,
  input  logic [AddrWidth:1]    A,
  inout  wire  [DataWidth-1:0]  D,
  output logic                  HC_IRQ,
  isp1761_bus_responder_if.master m,
  input  logic                  irq_in,
  output logic                  err_sticky
);

  localparam int unsigned SettleWidth = $clog2(SYNC_STAGES + 1);

  logic cs_n_sync, rd_n_sync, wr_n_sync;
  logic cs, rd, wr, req_wr, req_rd;

  state_e                 state_q, state_d;
  logic [AddrWidth:1]     a_q;
  logic [DataWidth-1:0]   d_q;
  logic [AvAddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [DataWidth-1:0]   rd_hold_q, rd_hold_d;
  logic                   err_q, err_set;
  logic                   irq_q;
  logic [SettleWidth-1:0] settle_q;
  logic                   settle_done;
  logic                   d_oe;

  isp1761_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
    .clk_i(csi_clk), .rst_i(csi_reset), .d_i(CS_N), .q_o(cs_n_sync)
  );
  isp1761_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_rd (
    .clk_i(csi_clk), .rst_i(csi_reset), .d_i(RD_N), .q_o(rd_n_sync)
  );
  isp1761_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_wr (
    .clk_i(csi_clk), .rst_i(csi_reset), .d_i(WR_N), .q_o(wr_n_sync)
  );

  assign cs     = ~cs_n_sync;
  assign rd     = ~rd_n_sync;
  assign wr     = ~wr_n_sync;
  assign req_wr = cs & wr & ~rd;
  assign req_rd = cs & rd & ~wr;

  // The synchronisers reset to "deasserted", so a strobe held through reset only becomes
  // visible SYNC_STAGES clocks later. Hold WAIT_RELEASE until the chains reflect the pins.
  assign settle_done = (settle_q == '0);

`ifdef ISP1761_RESP_TIMEOUT_EN
  localparam int unsigned TmoWidth = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TmoWidth-1:0] tmo_q, tmo_d;
  logic                tmo_hit;

  assign tmo_hit = (tmo_q == TmoWidth'(TIMEOUT_CYCLES - 1));

  // Counts stalled cycles; any state change (including entry into WR/RD) clears it.
  always_comb begin
    tmo_d = '0;
    if ((state_q == StWr || state_q == StRd) && state_d == state_q) begin
      tmo_d = tmo_q + TmoWidth'(1);
    end
  end

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_DATA, TIMEOUT_CYCLES};
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_hold_d = rd_hold_q;
    err_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs && rd && wr) begin
          err_set = 1'b1;
          state_d = StWaitRelease;
        end else if (req_wr) begin
          addr_d  = a_q[AvAddrWidth:1];
          wdata_d = d_q;
          state_d = StWr;
        end else if (req_rd) begin
          addr_d  = a_q[AvAddrWidth:1];
          state_d = StRd;
        end
      end
      StWr: begin
        if (!m.waitrequest) begin
          state_d = StWaitRelease;
`ifdef ISP1761_RESP_TIMEOUT_EN
        end else if (tmo_hit) begin
          err_set = 1'b1;
          state_d = StWaitRelease;
`endif
        end
      end
      StRd: begin
        if (!m.waitrequest) begin
          rd_hold_d = m.readdata;
          state_d   = StDrive;
`ifdef ISP1761_RESP_TIMEOUT_EN
        end else if (tmo_hit) begin
          err_set   = 1'b1;
          rd_hold_d = TIMEOUT_DATA;
          state_d   = StDrive;
`endif
        end
      end
      StDrive: begin
        if (!(cs && rd)) state_d = StIdle;
      end
      StWaitRelease: begin
        if (settle_done && (!cs || (!rd && !wr))) state_d = StIdle;
      end
      default: state_d = StWaitRelease;
    endcase
  end

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      state_q   <= StWaitRelease;
      settle_q  <= SettleWidth'(SYNC_STAGES);
      a_q       <= '0;
      d_q       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_hold_q <= '0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (!settle_done) settle_q <= settle_q - SettleWidth'(1);
      a_q       <= A;
      d_q       <= D;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_hold_q <= rd_hold_d;
      err_q     <= err_q | err_set;
      irq_q     <= irq_in;
    end
  end

  logic unused_a_msb;
  assign unused_a_msb = a_q[AddrWidth];

  // Release D in the reset cycle itself rather than waiting for the state register.
  assign d_oe = ~csi_reset & (state_q == StDrive) & cs & rd;
  assign D    = d_oe ? rd_hold_q : {DataWidth{1'bz}};

  assign m.address   = addr_q;
  assign m.writedata = wdata_q;
  assign m.read      = (state_q == StRd);
  assign m.write     = (state_q == StWr);
  assign HC_IRQ      = irq_q;
  assign err_sticky  = err_q;

endmodule

// File: tb/tb_isp1761_bus_responder.sv
// Scoreboarded bench for isp1761_bus_responder: host tasks drive bus accesses and push the
// expected Avalon transfers and read data; a monitor pops and compares as the DUT responds.
// Build with ISP1761_RESP_TIMEOUT_EN defined to also exercise the Avalon timeout.
module tb_isp1761_bus_responder;
  import isp1761_bus_responder_pkg::*;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned Hold       = 12;

  logic        clk = 1'b0;
  logic        csi_reset;
  logic        cs_n, rd_n, wr_n;
  logic [17:1] a;
  wire  [31:0] d_bus;
  logic        tb_d_oe;
  logic [31:0] tb_d;
  logic        hc_irq, irq_in, err_sticky;

  isp1761_bus_responder_if av();

  always #5 clk = ~clk;

  assign d_bus = tb_d_oe ? tb_d : 32'bz;

  isp1761_bus_responder #(.SYNC_STAGES(SyncStages)) dut (
    .csi_clk(clk), .csi_reset(csi_reset), .CS_N(cs_n), .RD_N(rd_n), .WR_N(wr_n),
    .A(a), .D(d_bus), .HC_IRQ(hc_irq), .m(av), .irq_in(irq_in), .err_sticky(err_sticky)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [15:0] addr);
    return {addr ^ 16'hA5C3, ~addr};
  endfunction

  // Avalon slave: register file with a programmable number of stall cycles per request.
  logic [31:0] slave_mem [65536];
  bit          slave_written [65536];
  int unsigned stall_target = 0;
  logic        stuck = 1'b0;
  int unsigned wait_cnt;

  assign av.waitrequest = (av.read || av.write) && (stuck || (wait_cnt < stall_target));
  assign av.readdata    = slave_written[av.address] ? slave_mem[av.address]
                                                    : init_word(av.address);

  always @(posedge clk) begin
    if (csi_reset || !(av.read || av.write)) begin
      wait_cnt <= 0;
    end else if (av.waitrequest) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
      if (av.write) begin
        slave_mem[av.address]     <= av.writedata;
        slave_written[av.address] <= 1'b1;
      end
    end
  end

  // Reference model and scoreboard queues.
  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } av_exp_t;

  av_exp_t     exp_av[$];
  logic [31:0] exp_rd[$];
  logic [31:0] model_mem [int unsigned];

  function automatic logic [31:0] model_read(input logic [15:0] addr);
    if (model_mem.exists(addr)) return model_mem[addr];
    return init_word(addr);
  endfunction

  int unsigned read_cycles, write_cycles, xfers;

  initial begin
    av_exp_t e;
    logic    prev_oe;
    read_cycles  = 0;
    write_cycles = 0;
    xfers        = 0;
    prev_oe      = 1'b0;
    forever begin
      @(negedge clk);
      if (csi_reset) begin
        prev_oe = 1'b0;
        continue;
      end
      if (av.read)  read_cycles++;
      if (av.write) write_cycles++;
      if ((av.read || av.write) && !av.waitrequest) begin
        xfers++;
        check("xfer_expected", 32'(exp_av.size() != 0), 32'd1);
        if (exp_av.size() != 0) begin
          e = exp_av.pop_front();
          check("xfer_kind", 32'(av.write), 32'(e.wr));
          check("xfer_addr", 32'(av.address), 32'(e.addr));
          if (e.wr) check("xfer_wdata", av.writedata, e.data);
        end
      end
      if (dut.d_oe && !prev_oe) begin
        check("drive_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) check("d_read_data", d_bus, exp_rd.pop_front());
      end
      prev_oe = dut.d_oe;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the number of clocks from strobe assertion to the first m_write cycle.
  task automatic bus_write(input logic [17:0] baddr, input logic [31:0] data,
                           input int unsigned stall, input int hold, output int lat);
    logic [15:0] w;
    w = baddr[16:1];
    stall_target = stall;
    exp_av.push_back('{wr: 1'b1, addr: w, data: data});
    model_mem[w] = data;
    a = baddr[17:1];
    tb_d = data;
    tb_d_oe = 1'b1;
    cs_n = 1'b0;
    wr_n = 1'b0;
    lat = -1;
    for (int i = 1; i <= hold; i++) begin
      tick(1);
      if (av.write && lat < 0) lat = i;
    end
    cs_n = 1'b1;
    wr_n = 1'b1;
    tb_d_oe = 1'b0;
    tick(6);
  endtask

  // Returns the number of clocks from RD_N falling to D first being driven.
  task automatic bus_read(input logic [17:0] baddr, input int unsigned stall, input int hold,
                          input bit expect_xfer, input logic [31:0] exp_data, output int lat);
    logic [15:0] w;
    w = baddr[16:1];
    stall_target = stall;
    if (expect_xfer) exp_av.push_back('{wr: 1'b0, addr: w, data: 32'h0});
    exp_rd.push_back(exp_data);
    a = baddr[17:1];
    tb_d_oe = 1'b0;
    cs_n = 1'b0;
    rd_n = 1'b0;
    lat = -1;
    for (int i = 1; i <= hold; i++) begin
      tick(1);
      if (dut.d_oe && lat < 0) lat = i;
    end
    rd_n = 1'b1;
    cs_n = 1'b1;
    tick(SyncStages + 1);
    check("d_released", 32'(dut.d_oe), 32'd0);
    tick(4);
  endtask

  initial begin
    int          lat;
    int unsigned base_r, base_w, base_x;
    logic [17:0] ba;
    logic [31:0] dat;
    logic        v;
    bit          found;

    csi_reset = 1'b1;
    cs_n = 1'b1;
    rd_n = 1'b1;
    wr_n = 1'b1;
    a = '0;
    tb_d = '0;
    tb_d_oe = 1'b0;
    irq_in = 1'b0;
    tick(4);
    check("rst_m_read", 32'(av.read), 32'd0);
    check("rst_m_write", 32'(av.write), 32'd0);
    check("rst_m_address", 32'(av.address), 32'd0);
    check("rst_m_writedata", av.writedata, 32'd0);
    check("rst_hc_irq", 32'(hc_irq), 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    check("rst_d_released", 32'(dut.d_oe), 32'd0);
    csi_reset = 1'b0;
    tick(5);

    // Directed write: byte address 0x304 maps to word address 0x182.
    base_w = write_cycles;
    bus_write(18'h00304, 32'hCAFEF00D, 0, 10, lat);
    check("wr_latency", 32'(lat), 32'(SyncStages + 1));
    check("wr_single_pulse", write_cycles - base_w, 32'd1);

    // Directed read with three stall cycles.
    bus_write(18'h00A10, 32'h12345678, 1, Hold, lat);
    base_r = read_cycles;
    bus_read(18'h00A10, 3, Hold, 1'b1, model_read(16'h0508), lat);
    check("rd_m_read_cycles", read_cycles - base_r, 32'd4);
    check("rd_d_latency", 32'(lat), 32'(SyncStages + 2 + 3));

    // Read strobe held for 40 cycles: still a single transfer.
    base_r = read_cycles;
    base_x = xfers;
    bus_read(18'h00304, 0, 40, 1'b1, model_read(16'h0182), lat);
    check("held_rd_cycles", read_cycles - base_r, 32'd1);
    check("held_rd_xfers", xfers - base_x, 32'd1);

    // Write strobe without chip select must be ignored.
    base_x = xfers;
    base_w = write_cycles;
    tb_d = 32'h55AA55AA;
    tb_d_oe = 1'b1;
    wr_n = 1'b0;
    tick(Hold);
    wr_n = 1'b1;
    tb_d_oe = 1'b0;
    tick(6);
    check("no_cs_xfers", xfers - base_x, 32'd0);
    check("no_cs_write", write_cycles - base_w, 32'd0);

    // Randomised traffic with random stalls and random A[17].
    for (int i = 0; i < 30; i++) begin
      ba  = 18'($urandom);
      dat = $urandom;
      if ($urandom_range(1, 0) == 1) begin
        bus_write(ba, dat, $urandom_range(3, 0), Hold, lat);
      end else begin
        bus_read(ba, $urandom_range(3, 0), Hold, 1'b1, model_read(ba[16:1]), lat);
      end
    end

    // RD and WR together: error flagged, nothing issued until both strobes are released.
    base_x = xfers;
    base_r = read_cycles;
    base_w = write_cycles;
    cs_n = 1'b0;
    rd_n = 1'b0;
    wr_n = 1'b0;
    tick(Hold);
    check("conflict_err", 32'(err_sticky), 32'd1);
    rd_n = 1'b1;
    tick(8);
    check("conflict_no_xfer", xfers - base_x, 32'd0);
    check("conflict_no_cycles", (read_cycles - base_r) + (write_cycles - base_w), 32'd0);
    wr_n = 1'b1;
    cs_n = 1'b1;
    tick(6);
    bus_read(18'h00304, 0, Hold, 1'b1, model_read(16'h0182), lat);
    check("err_stays_set", 32'(err_sticky), 32'd1);

    // Reset while driving D with RD_N still low.
    stall_target = 0;
    exp_av.push_back('{wr: 1'b0, addr: 16'h0508, data: 32'h0});
    exp_rd.push_back(model_read(16'h0508));
    a = 17'h00508;
    cs_n = 1'b0;
    rd_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (dut.d_oe) begin
        found = 1'b1;
        break;
      end
    end
    check("drive_reached", 32'(found), 32'd1);
    tick(1);
    @(negedge clk);
    csi_reset = 1'b1;
    #1;
    check("rst_d_release_now", 32'(dut.d_oe), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_m_read", 32'(av.read), 32'd0);
    check("rst_mid_d", 32'(dut.d_oe), 32'd0);
    check("rst_mid_err", 32'(err_sticky), 32'd0);
    check("rst_mid_addr", 32'(av.address), 32'd0);
    tick(2);
    csi_reset = 1'b0;
    base_x = xfers;
    base_r = read_cycles;
    tick(15);
    check("held_through_rst_xfers", xfers - base_x, 32'd0);
    check("held_through_rst_read", read_cycles - base_r, 32'd0);
    rd_n = 1'b1;
    cs_n = 1'b1;
    tick(6);
    bus_read(18'h00A10, 2, Hold, 1'b1, model_read(16'h0508), lat);

`ifdef ISP1761_RESP_TIMEOUT_EN
    // Slave never releases waitrequest: read times out and returns the timeout word.
    stuck = 1'b1;
    base_r = read_cycles;
    base_x = xfers;
    bus_read(18'h00304, 0, 300, 1'b0, TimeoutDataDefault, lat);
    stuck = 1'b0;
    check("tmo_read_cycles", read_cycles - base_r, 32'd255);
    check("tmo_no_xfer", xfers - base_x, 32'd0);
    check("tmo_err", 32'(err_sticky), 32'd1);
`endif

    // Interrupt forwarding through one register.
    for (int i = 0; i < 8; i++) begin
      v = 1'($urandom);
      irq_in = v;
      tick(1);
      check("hc_irq", 32'(hc_irq), 32'(v));
    end

    tick(4);
    check("av_queue_drained", 32'(exp_av.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
